// File: rtl/dispatcher.sv
// Receive side of the collector packet format: validates the header beat and
// unpacks payload beats onto the scanner beat interface through one output register.
module dispatcher #(
  parameter logic [23:0] MAGIC = 24'hAECAFE,
  parameter logic [7:0]  FLAGS = 8'h03
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] s_axis_tdata,
  input  logic [31:0]  s_axis_tstrb,
  input  logic [127:0] s_axis_tuser,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic         dsp_dvld_scn,
  output logic [7:0]   dsp_cmd_scn,
  output logic [23:0]  dsp_id_scn,
  output logic [255:0] dsp_data_scn,
  output logic [31:0]  dsp_bvld_scn,
  output logic         dsp_end_scn,
  input  logic         scn_rdy_dsp,
  output logic [15:0]  hdr_err_cnt,
  output logic [15:0]  len_err_cnt
);

  typedef enum logic [1:0] {HDR, PAY, DROP} state_t;

  state_t      state;
  logic [7:0]  cmd_sh;
  logic [23:0] id_sh;
  logic [7:0]  exp_beats;
  logic [7:0]  beat_cnt;
  logic        accept;
  logic        hdr_ok;
  logic        load;
  logic        xfer;
  logic        unused_ok;

  assign s_axis_tready = (state == PAY) ? (~dsp_dvld_scn | scn_rdy_dsp) : 1'b1;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign hdr_ok = (s_axis_tdata[23:0] == MAGIC) && (s_axis_tdata[63:56] == FLAGS);
  assign load   = accept && (state == PAY);
  assign xfer   = dsp_dvld_scn & scn_rdy_dsp;
  assign unused_ok = ^{s_axis_tuser[127:13], s_axis_tuser[4:0]};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HDR;
      cmd_sh       <= '0;
      id_sh        <= '0;
      exp_beats    <= '0;
      beat_cnt     <= '0;
      dsp_dvld_scn <= 1'b0;
      dsp_cmd_scn  <= '0;
      dsp_id_scn   <= '0;
      dsp_data_scn <= '0;
      dsp_bvld_scn <= '0;
      dsp_end_scn  <= 1'b0;
      hdr_err_cnt  <= '0;
      len_err_cnt  <= '0;
    end else begin
      if (xfer)
        dsp_dvld_scn <= 1'b0;
      // Header fields come from the shadow so a waiting end beat keeps its own cmd/id.
      if (load) begin
        dsp_dvld_scn <= 1'b1;
        dsp_data_scn <= s_axis_tdata;
        dsp_bvld_scn <= s_axis_tstrb;
        dsp_end_scn  <= s_axis_tlast;
        dsp_cmd_scn  <= cmd_sh;
        dsp_id_scn   <= id_sh;
      end
      case (state)
        HDR: begin
          if (accept) begin
            if (s_axis_tlast) begin
              hdr_err_cnt <= sat_inc(hdr_err_cnt);
            end else if (hdr_ok) begin
              cmd_sh    <= s_axis_tdata[31:24];
              id_sh     <= s_axis_tdata[55:32];
              exp_beats <= s_axis_tuser[12:5];
              beat_cnt  <= 8'd1;
              state     <= PAY;
            end else begin
              hdr_err_cnt <= sat_inc(hdr_err_cnt);
              state       <= DROP;
            end
          end
        end
        PAY: begin
          if (load) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (s_axis_tlast) begin
              state <= HDR;
              if (beat_cnt + 8'd1 != exp_beats)
                len_err_cnt <= sat_inc(len_err_cnt);
            end
          end
        end
        DROP: begin
          if (accept && s_axis_tlast)
            state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule
